// File: rtl/fixed_to_bcd_if.sv
// rtl/fixed_to_bcd_if.sv - handshake bundle between producer, formatter and display driver
`timescale 1ns/1ps
interface fixed_to_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sign;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [DIGITS-1:0]     out_dp;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_bcd, out_dp
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_bcd, out_dp
    );
endinterface

// File: rtl/fixed_to_bcd.sv
// rtl/fixed_to_bcd.sv - signed fixed-point to packed BCD, iterative double-dabble
`timescale 1ns/1ps
module fixed_to_bcd #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int FRAC_DIGITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fixed_to_bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic            out_valid_q;
    logic            out_sign_q;
    logic [BW-1:0]   out_bcd_q;
    logic [WIDTH-1:0] in_mag;

    // Most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        in_mag = bus.in_data[WIDTH-1] ? ((~bus.in_data) + WIDTH'(1)) : bus.in_data;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q  <= bus.in_data[WIDTH-1];
                        mag_q   <= in_mag;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // A set sign bit always implies a nonzero magnitude.
                        out_bcd_q   <= bcd_d;
                        out_sign_q  <= sign_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_dp    = DIGITS'(1) << FRAC_DIGITS;
endmodule

// File: tb/tb_fixed_to_bcd.sv
// tb/tb_fixed_to_bcd.sv - directed and random checks of fixed_to_bcd against a decimal model
`timescale 1ns/1ps
module tb_fixed_to_bcd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fixed_to_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

    fixed_to_bcd #(.WIDTH(16), .DIGITS(5), .FRAC_DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] model_bcd(input logic [15:0] v);
        int m;
        logic [19:0] r;
        m = int'($signed(v));
        if (m < 0) m = -m;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic present(input logic [15:0] v);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic wait_result(input logic [15:0] v, input string tag);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd16);
        check({tag, "_sign"}, 32'(bus.out_sign), 32'(v[15]));
        check({tag, "_bcd"}, 32'(bus.out_bcd), 32'(model_bcd(v)));
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("handoff_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] dir [5];
        logic [15:0] v;
        int last_cyc;
        dir[0] = 16'd10000; dir[1] = 16'hFFFF; dir[2] = 16'h0000;
        dir[3] = 16'h8000;  dir[4] = 16'h7FFF;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
        check("rst_out_sign", 32'(bus.out_sign), 32'd0);
        check("out_dp", 32'(bus.out_dp), 32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed values including both extremes and zero
        check("exp_10000", 32'(model_bcd(16'd10000)), 32'h10000);
        check("exp_8000", 32'(model_bcd(16'h8000)), 32'h32768);
        for (int i = 0; i < 5; i++) begin
            present(dir[i]);
            bus.in_valid = 1'b0;
            wait_result(dir[i], "dir");
            handoff();
        end

        // Backpressure: result held, new input waits for the handoff
        bus.out_ready = 1'b0;
        present(16'd1234);
        bus.in_valid = 1'b0;
        wait_result(16'd1234, "bp");
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd4321;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_bcd", 32'(bus.out_bcd), 32'h01234);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        handoff();
        check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_taken", 32'(bus.in_ready), 32'd0);
        wait_result(16'd4321, "bp_new");
        handoff();

        // Reset mid-conversion discards the partial result
        present(16'd5000);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_bcd", 32'(bus.out_bcd), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        present(16'd8660);
        bus.in_valid = 1'b0;
        wait_result(16'd8660, "post_rst");
        handoff();

        // Random stream with in_valid held high: one result every 18 cycles
        bus.out_ready = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom);
            bus.in_data  = v;
            bus.in_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            wait_result(v, "rnd");
            if (i > 0) check("rnd_period", 32'(cyc - last_cyc), 32'd18);
            last_cyc = cyc;
            @(posedge clk); @(negedge clk);
        end
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
